// File: rtl/pe_collector_pkg.sv
// Shared widths and the fixed-width round/shift/saturate reference function.
// Latency: n/a (package, no logic of its own).
// Backpressure: n/a.
package pe_collector_pkg;

    localparam int C_W     = 19;
    localparam int OUT_W   = 8;
    localparam int SHIFT_W = 4;

    // Saturation bounds held at C_W+1 bits so they compare directly against
    // the widened rounding result.
    localparam logic signed [C_W:0] SAT_MAX = (C_W+1)'((1 << (OUT_W-1)) - 1);
    localparam logic signed [C_W:0] SAT_MIN = ~SAT_MAX;

    // Half-up rounding right shift of a two's-complement accumulator, then
    // clamp to the signed OUT_W range. Shift 0 passes the value through.
    function automatic logic [OUT_W-1:0] round_shift_sat(input logic [C_W-1:0]     c,
                                                         input logic [SHIFT_W-1:0] s);
        logic signed [C_W:0] ext;
        logic        [C_W:0] half;
        logic signed [C_W:0] r;
        logic [OUT_W-1:0]    res;
        ext  = {c[C_W-1], c};
        half = '0;
        r    = ext;
        if (s != '0) begin
            half = (C_W+1)'(1) << (s - SHIFT_W'(1));
            r    = $signed(ext + half) >>> s;
        end
        res = r[OUT_W-1:0];
        if (r > SAT_MAX) begin
            res = SAT_MAX[OUT_W-1:0];
        end else if (r < SAT_MIN) begin
            res = SAT_MIN[OUT_W-1:0];
        end
        return res;
    endfunction

endpackage

// File: rtl/result_fifo.sv
// Show-ahead FIFO: head entry is visible on head_dat_o whenever not empty.
// Latency: a push is visible at the head the cycle after the write edge.
// Backpressure: a push while full is accepted only if a pop happens that cycle.
//
// Ports: clock/reset (async active-high), push_i/push_dat_i write side,
// pop_i read side (ignored when empty), head_dat_o (0 when empty),
// count_o occupancy, full_o/empty_o derived from count_o.
module result_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         push_dat_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         head_dat_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             wr_en;
    logic             rd_en;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

    // A pop frees the slot the same cycle, so a full FIFO still takes a push.
    assign wr_en = push_i && (!full_o || pop_i);
    assign rd_en = pop_i && !empty_o;

    // Gate the head so stale storage never leaks out after reset or drain.
    assign head_dat_o = empty_o ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (rd_en) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        count_d = count_q + CW'(wr_en) - CW'(rd_en);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= push_dat_i;
        end
    end

endmodule

// File: rtl/pe_result_collector.sv
// Collects completed PE accumulators, rounds/saturates them and queues them.
// Latency: beat sampled at edge t is at the FIFO head after edge t+2.
// Backpressure: io_out_ready pops; a result arriving at a full FIFO with no pop is dropped and io_overflow sticks.
//
// Ports: clock, reset (async active-high); io_in_c/io_in_valid/
// io_in_control_propagate/io_in_control_shift from the tile; io_out_valid/
// io_out_bits/io_out_ready drain port; io_count occupancy; io_overflow sticky.
module pe_result_collector #(
    parameter int C_W     = pe_collector_pkg::C_W,
    parameter int OUT_W   = pe_collector_pkg::OUT_W,
    parameter int SHIFT_W = pe_collector_pkg::SHIFT_W,
    parameter int DEPTH   = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [C_W-1:0]         io_in_c,
    input  logic                   io_in_valid,
    input  logic                   io_in_control_propagate,
    input  logic [SHIFT_W-1:0]     io_in_control_shift,
    output logic                   io_out_valid,
    output logic [OUT_W-1:0]       io_out_bits,
    input  logic                   io_out_ready,
    output logic [$clog2(DEPTH):0] io_count,
    output logic                   io_overflow
);

    localparam logic signed [C_W:0] SAT_MAX = (C_W+1)'((1 << (OUT_W-1)) - 1);
    localparam logic signed [C_W:0] SAT_MIN = ~SAT_MAX;

    // Window tracking
    logic seen_q, seen_d;
    logic prev_prop_q, prev_prop_d;
    logic emit;

    // Stage 1: captured beat
    logic               s1_vld_q;
    logic [C_W-1:0]     s1_c_q;
    logic [SHIFT_W-1:0] s1_shift_q;

    // Stage 2: rounded result waiting to be written
    logic               s2_vld_q;
    logic [OUT_W-1:0]   s2_res_q;

    logic signed [C_W:0] ext;
    logic        [C_W:0] half;
    logic signed [C_W:0] rnd;
    logic [OUT_W-1:0]    sat;

    logic ovf_q, ovf_d;
    logic fifo_full;
    logic fifo_empty;
    logic pop;

    // The first valid beat only primes prev_prop; afterwards any change of
    // propagate on a valid beat marks the end of a window.
    always_comb begin
        seen_d      = seen_q;
        prev_prop_d = prev_prop_q;
        emit        = 1'b0;
        if (io_in_valid) begin
            seen_d      = 1'b1;
            prev_prop_d = io_in_control_propagate;
            emit        = seen_q && (io_in_control_propagate != prev_prop_q);
        end
    end

    // One extra bit of headroom keeps c + 2^(s-1) from wrapping.
    always_comb begin
        ext  = {s1_c_q[C_W-1], s1_c_q};
        half = '0;
        rnd  = ext;
        if (s1_shift_q != '0) begin
            half = (C_W+1)'(1) << (s1_shift_q - SHIFT_W'(1));
            rnd  = $signed(ext + half) >>> s1_shift_q;
        end
        sat = rnd[OUT_W-1:0];
        if (rnd > SAT_MAX) begin
            sat = SAT_MAX[OUT_W-1:0];
        end else if (rnd < SAT_MIN) begin
            sat = SAT_MIN[OUT_W-1:0];
        end
    end

    assign io_out_valid = !fifo_empty;
    assign pop          = io_out_valid && io_out_ready;

    // Drop is decided in the write cycle against that same cycle's pop.
    assign ovf_d       = ovf_q || (s2_vld_q && fifo_full && !pop);
    assign io_overflow = ovf_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            seen_q      <= 1'b0;
            prev_prop_q <= 1'b0;
            s1_vld_q    <= 1'b0;
            s1_c_q      <= '0;
            s1_shift_q  <= '0;
            s2_vld_q    <= 1'b0;
            s2_res_q    <= '0;
            ovf_q       <= 1'b0;
        end else begin
            seen_q      <= seen_d;
            prev_prop_q <= prev_prop_d;
            s1_vld_q    <= emit;
            s1_c_q      <= io_in_c;
            s1_shift_q  <= io_in_control_shift;
            s2_vld_q    <= s1_vld_q;
            s2_res_q    <= sat;
            ovf_q       <= ovf_d;
        end
    end

    result_fifo #(
        .WIDTH (OUT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock      (clock),
        .reset      (reset),
        .push_i     (s2_vld_q),
        .push_dat_i (s2_res_q),
        .pop_i      (pop),
        .head_dat_o (io_out_bits),
        .count_o    (io_count),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty)
    );

endmodule

// File: tb/tb_pe_result_collector.sv
// Scenario bench for pe_result_collector with a queue scoreboard.
// Latency: n/a.
// Backpressure: io_out_ready is driven per scenario.
module tb_pe_result_collector;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [18:0] io_in_c = '0;
    logic        io_in_valid = 1'b0;
    logic        io_in_control_propagate = 1'b0;
    logic [3:0]  io_in_control_shift = '0;
    logic        io_out_valid;
    logic [7:0]  io_out_bits;
    logic        io_out_ready = 1'b0;
    logic [2:0]  io_count;
    logic        io_overflow;

    int errors  = 0;
    int checks  = 0;
    int out_cnt = 0;

    logic [7:0] exp_q[$];
    logic [7:0] mon_exp;
    bit         sb_keep = 1'b1;
    bit         m_seen  = 1'b0;
    logic       m_prev  = 1'b0;

    pe_result_collector dut (
        .clock                   (clock),
        .reset                   (reset),
        .io_in_c                 (io_in_c),
        .io_in_valid             (io_in_valid),
        .io_in_control_propagate (io_in_control_propagate),
        .io_in_control_shift     (io_in_control_shift),
        .io_out_valid            (io_out_valid),
        .io_out_bits             (io_out_bits),
        .io_out_ready            (io_out_ready),
        .io_count                (io_count),
        .io_overflow             (io_overflow)
    );

    always #5 clock = ~clock;

    // Every accepted output is checked against the oldest expected result.
    always @(negedge clock) begin
        if (!reset && io_out_valid && io_out_ready) begin
            checks++;
            out_cnt++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_output: got %h, none expected", io_out_bits);
            end else begin
                mon_exp = exp_q.pop_front();
                if (io_out_bits !== mon_exp) begin
                    errors++;
                    $display("FAIL output_value: got %h, expected %h", io_out_bits, mon_exp);
                end
            end
        end
    end

    // One input beat, held across one sampling edge; the model mirrors the
    // window rule and queues the expected result for emitting beats.
    task automatic beat(input logic [18:0] c, input logic [3:0] s, input logic p, input logic v);
        io_in_c                 = c;
        io_in_control_shift     = s;
        io_in_control_propagate = p;
        io_in_valid             = v;
        if (v) begin
            if (m_seen && (p !== m_prev) && sb_keep)
                exp_q.push_back(pe_collector_pkg::round_shift_sat(c, s));
            m_seen = 1'b1;
            m_prev = p;
        end
        @(posedge clock);
        #1;
        io_in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 60 && (exp_q.size() != 0 || io_count != 0); i++)
            @(negedge clock);
        checks++;
        if (exp_q.size() != 0 || io_count != 0) begin
            errors++;
            $display("FAIL %s_drain_timeout: pending=%0d count=%0d, required 0/0", name, exp_q.size(), io_count);
        end
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset;
        #2;
        checks++; if (io_out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b, expected 0", io_out_valid); end
        checks++; if (io_out_bits !== 8'h00) begin errors++; $display("FAIL reset_bits: got %h, expected 00", io_out_bits); end
        checks++; if (io_count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d, expected 0", io_count); end
        checks++; if (io_overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b, expected 0", io_overflow); end
        @(posedge clock);
        #1;
        reset  = 1'b0;
        m_seen = 1'b0;
        m_prev = 1'b0;
    endtask

    task automatic test_basic;
        int base;
        base = out_cnt;
        io_out_ready = 1'b1;
        beat(19'd100, 4'd0, 1'b0, 1'b1);
        beat(19'd100, 4'd0, 1'b0, 1'b1);
        beat(19'd100, 4'd2, 1'b1, 1'b1);
        @(posedge clock);
        @(posedge clock);
        @(negedge clock);
        checks++; if (io_count !== 3'd1) begin errors++; $display("FAIL basic_count1: got %0d, expected 1", io_count); end
        checks++; if (io_out_bits !== 8'h19) begin errors++; $display("FAIL basic_bits: got %h, expected 19", io_out_bits); end
        @(negedge clock);
        checks++; if (io_count !== 3'd0) begin errors++; $display("FAIL basic_count0: got %0d, expected 0", io_count); end
        idle(3);
        checks++; if (out_cnt - base !== 1) begin errors++; $display("FAIL basic_outputs: got %0d, expected 1", out_cnt - base); end
    endtask

    task automatic test_rounding;
        logic [18:0] cs [3];
        logic [3:0]  ss [3];
        logic [7:0]  es [3];
        cs = '{19'h7FFFB, 19'd1000, 19'h7FC18};
        ss = '{4'd1, 4'd0, 4'd0};
        es = '{8'hFE, 8'h7F, 8'h80};
        io_out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            beat(cs[i], ss[i], ~m_prev, 1'b1);
            @(posedge clock);
            @(posedge clock);
            @(negedge clock);
            checks++;
            if (io_out_valid !== 1'b1 || io_out_bits !== es[i]) begin
                errors++;
                $display("FAIL round_case%0d: got valid=%b bits=%h, expected valid=1 bits=%h", i, io_out_valid, io_out_bits, es[i]);
            end
            @(posedge clock);
            #1;
        end
        wait_drain("rounding");
    endtask

    task automatic test_random;
        io_out_ready = 1'b1;
        for (int i = 0; i < 12; i++)
            beat(19'($urandom), 4'($urandom_range(0, 15)), ~m_prev, 1'b1);
        wait_drain("random");
    endtask

    task automatic test_back_to_back_full;
        io_out_ready = 1'b0;
        for (int i = 0; i < 12; i++) begin
            // Ready rises exactly when the fifth result reaches the write stage.
            if (i == 6) io_out_ready = 1'b1;
            beat(19'(i * 37 + 3), 4'(i % 3), ~m_prev, 1'b1);
            if (i >= 6) begin
                checks++;
                if (io_count !== 3'd4) begin errors++; $display("FAIL stream_count%0d: got %0d, expected 4", i, io_count); end
            end
        end
        wait_drain("stream");
        checks++; if (io_overflow !== 1'b0) begin errors++; $display("FAIL stream_overflow: got %b, expected 0", io_overflow); end
    endtask

    task automatic test_valid_gap;
        int base;
        io_out_ready = 1'b1;
        if (m_prev) beat(19'd5, 4'd0, 1'b0, 1'b1);
        wait_drain("gap_setup");
        base = out_cnt;
        beat(19'd7, 4'd0, 1'b0, 1'b1);
        beat(19'd9, 4'd0, 1'b1, 1'b0);
        beat(19'd11, 4'd0, 1'b0, 1'b1);
        idle(5);
        checks++; if (out_cnt - base !== 0) begin errors++; $display("FAIL gap_emits: got %0d, expected 0", out_cnt - base); end
        checks++; if (io_count !== 3'd0) begin errors++; $display("FAIL gap_count: got %0d, expected 0", io_count); end
    endtask

    task automatic test_overflow;
        logic [7:0] head;
        io_out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            sb_keep = (i < 4);
            beat(19'(i * 64 + 10), 4'd1, ~m_prev, 1'b1);
        end
        sb_keep = 1'b1;
        idle(3);
        checks++; if (io_count !== 3'd4) begin errors++; $display("FAIL ovf_count: got %0d, expected 4", io_count); end
        checks++; if (io_overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b, expected 1", io_overflow); end
        head = exp_q[0];
        checks++; if (io_out_bits !== head) begin errors++; $display("FAIL ovf_head: got %h, expected %h", io_out_bits, head); end
        idle(3);
        checks++; if (io_out_bits !== head) begin errors++; $display("FAIL ovf_stable: got %h, expected %h", io_out_bits, head); end
        io_out_ready = 1'b1;
        wait_drain("overflow");
        checks++; if (io_overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b, expected 1", io_overflow); end
    endtask

    task automatic test_reset_mid_drain;
        int base;
        io_out_ready = 1'b0;
        for (int i = 0; i < 3; i++)
            beat(19'(i + 20), 4'd0, ~m_prev, 1'b1);
        idle(3);
        checks++; if (io_count !== 3'd3) begin errors++; $display("FAIL mid_count3: got %0d, expected 3", io_count); end
        io_out_ready = 1'b1;
        @(negedge clock);
        #2;
        reset = 1'b1;
        #1;
        checks++; if (io_out_valid !== 1'b0) begin errors++; $display("FAIL mid_async_valid: got %b, expected 0", io_out_valid); end
        checks++; if (io_count !== 3'd0) begin errors++; $display("FAIL mid_async_count: got %0d, expected 0", io_count); end
        checks++; if (io_overflow !== 1'b0) begin errors++; $display("FAIL mid_async_overflow: got %b, expected 0", io_overflow); end
        exp_q.delete();
        m_seen = 1'b0;
        m_prev = 1'b0;
        @(posedge clock);
        #1;
        reset = 1'b0;
        base = out_cnt;
        beat(19'd50, 4'd0, 1'b1, 1'b1);
        beat(19'd60, 4'd0, 1'b0, 1'b1);
        @(posedge clock);
        @(posedge clock);
        @(negedge clock);
        checks++; if (io_out_bits !== 8'h3C) begin errors++; $display("FAIL mid_after_bits: got %h, expected 3c", io_out_bits); end
        wait_drain("mid_after");
        checks++; if (out_cnt - base !== 1) begin errors++; $display("FAIL mid_after_outputs: got %0d, expected 1", out_cnt - base); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_rounding();
        test_random();
        test_back_to_back_full();
        test_valid_gap();
        test_overflow();
        test_reset_mid_drain();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

endmodule

// File: doc/pe_result_collector.md
# pe_result_collector

Receive-side endpoint for a single-PE tile's output stream. It watches the tile's `c` result, `valid` and control outputs, and detects the end of each accumulation window from a `propagate` toggle. For each completed accumulator it applies a rounding right-shift by the beat's `shift` value, saturates the result to 8-bit signed, and queues it in a small FIFO. The FIFO drains through a ready/valid port toward the scratchpad/accumulator write path.

## Interface
Parameters:
- `C_W`, 19: width of the incoming accumulator value (two's complement).
- `OUT_W`, 8: width of the emitted result (two's complement).
- `SHIFT_W`, 4: width of the shift control.
- `DEPTH`, 4: FIFO entries; power of two, at least 2.

Ports:
- `clock` in 1: single clock; all logic is rising-edge.
- `reset` in 1: asynchronous, active-high reset.
- `io_in_c` in C_W: accumulator value from the tile.
- `io_in_valid` in 1: beat qualifier from the tile.
- `io_in_control_propagate` in 1: propagate flag travelling with the beat.
- `io_in_control_shift` in SHIFT_W: right-shift amount for this beat.
- `io_out_valid` out 1: FIFO head is valid.
- `io_out_bits` out OUT_W: FIFO head value.
- `io_out_ready` in 1: downstream accepts the head.
- `io_count` out clog2(DEPTH)+1: current FIFO occupancy.
- `io_overflow` out 1: sticky flag; a result was dropped.

## Operation
- Tracking state: `seen` (reset 0) and `prev_prop` (reset 0). Both update only on beats where `io_in_valid`=1.
- Beat classification, for beats with `io_in_valid`=1:
  - `seen`=0: record `prev_prop`, set `seen`, no emit.
  - `seen`=1 and `propagate`≠`prev_prop`: emit. The `c` value on this beat is the completed accumulator.
  - `seen`=1 and `propagate`=`prev_prop`: no emit. Update `prev_prop`.
- Beats with `io_in_valid`=0 are ignored entirely and do not change `prev_prop`.
- Rounding, with s = `shift`:
  - s=0: pass `c` through unchanged.
  - s>0: r = (c + 2^(s-1)) >>> s, sign-extended. Compute in C_W+1 bits so the add cannot wrap.
  - Rounding is half-up toward +∞.
- Saturation: clamp r to [-2^(OUT_W-1), 2^(OUT_W-1)-1], i.e. [-128, 127] by default.
- FIFO: show-ahead.
  - `io_out_bits` is the head entry whenever `io_out_valid`=1.
  - Pop occurs on `io_out_valid && io_out_ready`.
- Full FIFO with a push and no pop: drop the new result, set `io_overflow`. The flag clears only on reset.
- Full FIFO with a push and a pop in the same cycle: both take effect and occupancy is unchanged.
- Empty FIFO with a push: no pop is possible that cycle, since `io_out_valid` is 0.
- Pointers wrap modulo DEPTH. Full/empty are derived from `io_count`.

## Timing
- Stage 1: register the emit decision, `c` and `shift`.
- Stage 2: round/saturate, then FIFO write at the end of the cycle.
- Latency: an emitting beat sampled at edge t appears on `io_out_*` in the cycle after edge t+2, if the FIFO was otherwise empty.
- Throughput: one result per cycle sustained while `io_out_ready`=1.
- Overflow is judged at the stage-2 write cycle against that cycle's pop.
- Reset values: `io_out_valid`=0, `io_out_bits`=0, `io_count`=0, `io_overflow`=0. Pipeline valids, `seen` and `prev_prop` are 0.
- Reset asserted mid-operation:
  - All queued and in-flight results are discarded immediately, with no clock needed.
  - After deassertion the first valid beat is again treated as `seen`=0.
- `io_out_bits` is stable while `io_out_valid`=1 and `io_out_ready`=0.

## Structure
- Shared package `pe_collector_pkg`:
  - width constants `C_W`, `OUT_W`, `SHIFT_W`;
  - function `round_shift_sat(c, s)` for reuse by the bench model.
- One sub-module: `result_fifo`, a parameterised show-ahead FIFO with width, depth, push, pop, count and full/empty.
- Edge detection, rounding and the overflow flag live in the top module.

## Test plan
- Reset release, then `valid`=1 with `prop`=0,0,1 and `c`=100, `shift`=2 on the third beat → exactly one output 25 (0x19) three edges later; `io_count` goes 1 then 0 with `ready`=1.
- Toggle beat with `c`=0x7FFFB (-5), `shift`=1 → output 0xFE (-2). Toggle beat with `c`=1000, `shift`=0 → 0x7F. Toggle beat with `c`=-1000, `shift`=0 → 0x80.
- `ready`=0, five consecutive toggling beats (`prop` alternating 0/1) → `io_count`=4, `io_overflow`=1, and the first four values are retained in order.
- FIFO full, `ready`=1 held, continuous toggle beats → `io_count` stays 4, no overflow, and output values follow inputs in order.
- Valid gaps: `prop`=1 with `valid`=0 between two `prop`=0 valid beats → no emit.
- Reset pulse mid-drain with 3 entries queued → `io_out_valid`=0 and `io_count`=0 asynchronously, and the next toggle after a fresh first beat emits normally.
